// File: rtl/bp_be_accel_wb_scheduler_if.sv
// Forward uncached-write channel and reverse completion channel between the
// write-back scheduler (master) and the memory-forward stream pump (slave).
interface bp_be_accel_wb_scheduler_if #(
    parameter int paddr_width_p = 40,
    parameter int data_width_p  = 128
);
    logic [paddr_width_p-1:0] fwd_addr;
    logic [data_width_p-1:0]  fwd_data;
    logic                     fwd_dest;
    logic                     fwd_v;
    logic                     fwd_ready_and;
    logic                     rev_v;

    modport master (
        output fwd_addr, fwd_data, fwd_dest, fwd_v,
        input  fwd_ready_and, rev_v
    );

    modport slave (
        input  fwd_addr, fwd_data, fwd_dest, fwd_v,
        output fwd_ready_and, rev_v
    );
endinterface

// File: rtl/bp_be_accel_wb_scheduler.sv
// Round-robin write-back scheduler: two per-destination address generators
// feed one registered forward beat slot, throttled by write credits.
module bp_be_accel_wb_scheduler #(
    parameter int paddr_width_p = 40,
    parameter int data_width_p  = 128,
    parameter int len_width_p   = 16,
    parameter int credits_p     = 8
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 cfg_v_i,
    input  logic                                 cfg_dest_i,
    input  logic [paddr_width_p-1:0]             cfg_base_i,
    input  logic [len_width_p-1:0]               cfg_len_i,
    input  logic [2*data_width_p-1:0]            req_data_i,
    input  logic [1:0]                           req_v_i,
    output logic [1:0]                           req_yumi_o,
    bp_be_accel_wb_scheduler_if.master           mem,
    output logic [$clog2(credits_p+1)-1:0]       credits_o,
    output logic                                 busy_o,
    output logic [1:0]                           done_o,
    output logic                                 err_o
);
    localparam int cw = $clog2(credits_p + 1);
    localparam logic [cw-1:0] credits_full = cw'(credits_p);

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DRAIN} dest_state_e;

    logic [cw-1:0]            credits_reg, credits_next;
    logic                     rr_reg, rr_next;
    logic                     err_reg, err_next;
    logic                     out_v_reg;
    logic [paddr_width_p-1:0] out_addr_reg;
    logic [data_width_p-1:0]  out_data_reg;
    logic                     out_dest_reg;

    logic [1:0]                    elig, grant, active_vec, drain_vec, done_vec, err_vec;
    logic [1:0][paddr_width_p-1:0] addr_all;
    logic                          any_grant, gnt_dest, can_load, drained, rev_ok, rev_err;

    // The slot can accept a new beat if empty or if its beat leaves this cycle.
    assign can_load  = ~out_v_reg | mem.fwd_ready_and;
    assign drained   = ~out_v_reg & (credits_reg == credits_full);
    assign rev_ok    = mem.rev_v & (credits_reg != credits_full);
    assign rev_err   = mem.rev_v & (credits_reg == credits_full);
    assign any_grant = |grant;
    assign gnt_dest  = grant[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dest
        dest_state_e              state_reg, state_next;
        logic [paddr_width_p-1:0] addr_reg, addr_next;
        logic [len_width_p-1:0]   rem_reg, rem_next;
        logic                     done_reg, done_next;
        logic                     zpend_reg, zpend_next;
        logic                     cfg_hit;

        assign cfg_hit        = cfg_v_i & (cfg_dest_i == 1'(gi));
        assign elig[gi]       = req_v_i[gi] & (state_reg == ST_ACTIVE) & (credits_reg != '0) & can_load;
        assign active_vec[gi] = (state_reg == ST_ACTIVE);
        assign drain_vec[gi]  = (state_reg == ST_DRAIN);
        assign done_vec[gi]   = done_reg;
        assign addr_all[gi]   = addr_reg;
        assign err_vec[gi]    = (cfg_hit & (state_reg != ST_IDLE)) |
                                (req_v_i[gi] & (state_reg != ST_ACTIVE));

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                state_reg <= ST_IDLE;
                addr_reg  <= '0;
                rem_reg   <= '0;
                done_reg  <= 1'b0;
                zpend_reg <= 1'b0;
            end else begin
                state_reg <= state_next;
                addr_reg  <= addr_next;
                rem_reg   <= rem_next;
                done_reg  <= done_next;
                zpend_reg <= zpend_next;
            end
        end

        always_comb begin
            state_next = state_reg;
            addr_next  = addr_reg;
            rem_next   = rem_reg;
            done_next  = done_reg;
            zpend_next = zpend_reg;
            case (state_reg)
                ST_IDLE: begin
                    if (cfg_hit) begin
                        addr_next = cfg_base_i;
                        rem_next  = cfg_len_i;
                        done_next = 1'b0;
                        if (cfg_len_i != '0) begin
                            state_next = ST_ACTIVE;
                            zpend_next = 1'b0;
                        end else begin
                            // Zero-length job completes in IDLE once traffic settles.
                            zpend_next = 1'b1;
                        end
                    end else if (zpend_reg && drained) begin
                        done_next  = 1'b1;
                        zpend_next = 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (grant[gi]) begin
                        addr_next = addr_reg + paddr_width_p'(16);
                        rem_next  = rem_reg - len_width_p'(1);
                        if (rem_reg == len_width_p'(1)) state_next = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drained) begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        grant = 2'b00;
        if (elig[rr_reg])       grant[rr_reg]  = 1'b1;
        else if (elig[~rr_reg]) grant[~rr_reg] = 1'b1;
    end

    always_comb begin
        rr_next      = any_grant ? ~gnt_dest : rr_reg;
        err_next     = err_reg | (|err_vec) | rev_err;
        credits_next = credits_reg;
        // Credits are reserved at grant and returned on completion.
        case ({any_grant, rev_ok})
            2'b10:   credits_next = credits_reg - cw'(1);
            2'b01:   credits_next = credits_reg + cw'(1);
            default: credits_next = credits_reg;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credits_reg  <= credits_full;
            rr_reg       <= 1'b0;
            err_reg      <= 1'b0;
            out_v_reg    <= 1'b0;
            out_addr_reg <= '0;
            out_data_reg <= '0;
            out_dest_reg <= 1'b0;
        end else begin
            credits_reg <= credits_next;
            rr_reg      <= rr_next;
            err_reg     <= err_next;
            if (any_grant) begin
                out_v_reg    <= 1'b1;
                out_addr_reg <= addr_all[gnt_dest];
                out_data_reg <= gnt_dest ? req_data_i[2*data_width_p-1:data_width_p]
                                         : req_data_i[data_width_p-1:0];
                out_dest_reg <= gnt_dest;
            end else if (mem.fwd_ready_and) begin
                out_v_reg <= 1'b0;
            end
        end
    end

    assign req_yumi_o   = grant;
    assign mem.fwd_v    = out_v_reg;
    assign mem.fwd_addr = out_addr_reg;
    assign mem.fwd_data = out_data_reg;
    assign mem.fwd_dest = out_dest_reg;
    assign credits_o    = credits_reg;
    assign done_o       = done_vec;
    assign err_o        = err_reg;
    assign busy_o       = (|active_vec) | (|drain_vec) | out_v_reg | (credits_reg != credits_full);
endmodule
